// File: rtl/dbus_ram_responder.sv
// Data-bus responder backed by a single-port word RAM with byte-enabled writes.
// Inserts p_wait_states busy cycles per transfer and closes each one with a single-cycle ack.
module dbus_ram_responder #(
    parameter int unsigned p_addr_width  = 10,
    parameter logic [31:0] p_base_addr   = 32'h0001_0000,
    parameter int unsigned p_wait_states = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] dbus_addr,
    input  logic [3:0]  dbus_be,
    input  logic        dbus_wr_en,
    input  logic [31:0] dbus_wr_data,
    input  logic        dbus_rd_en,
    output logic [31:0] dbus_rd_data,
    output logic        dbus_busy,
    output logic        dbus_ack
);

    localparam int unsigned DEPTH     = 1 << p_addr_width;
    localparam logic [3:0]  WAIT_LOAD = (p_wait_states == 0) ? 4'd0 : 4'(p_wait_states - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              wcnt;
    logic [3:0]              wcnt_nxt;
    logic                    sel;
    logic                    req;
    logic                    accept;
    logic [p_addr_width-1:0] word_idx;
    logic [31:0]             mem [DEPTH];
    logic                    unused_addr_lsb;

    assign sel             = (dbus_addr[31:p_addr_width+2] == p_base_addr[31:p_addr_width+2]);
    assign word_idx        = dbus_addr[p_addr_width+1:2];
    assign req             = (dbus_wr_en | dbus_rd_en) & sel;
    // The ACK cycle doubles as an idle slot so W=0 traffic can stream one transfer per clock.
    assign accept          = req & (state != S_WAIT);
    assign unused_addr_lsb = ^dbus_addr[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        unique case (state)
            S_IDLE, S_ACK: begin
                if (accept) begin
                    if (p_wait_states == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT;
                        wcnt_nxt  = WAIT_LOAD;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nxt = S_ACK;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dbus_busy = 1'b0;
        dbus_ack  = 1'b0;
        unique case (state)
            S_WAIT:  dbus_busy = 1'b1;
            S_ACK:   dbus_ack  = 1'b1;
            default: ;
        endcase
    end

    // RAM contents are deliberately not reset; a write made on an accept edge survives a later reset.
    always_ff @(posedge i_clk) begin
        if (accept && dbus_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (dbus_be[b]) begin
                    mem[word_idx][8*b +: 8] <= dbus_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Non-blocking read of the same edge gives read-first behaviour on a combined read/write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbus_rd_data <= 32'd0;
        end else if (accept && dbus_rd_en) begin
            dbus_rd_data <= mem[word_idx];
        end
    end

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Bench for dbus_ram_responder: two instances (W=0 and W=3) checked every cycle
// against a transaction-level model of accept edges, busy/ack windows and RAM contents.
module tb_dbus_ram_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          AW   = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  be    [2];
    logic        wr    [2];
    logic        rd    [2];
    logic        busy  [2];
    logic        ack   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dbus_ram_responder #(
        .p_addr_width (AW),
        .p_base_addr  (BASE),
        .p_wait_states(0)
    ) u_dut0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .dbus_addr   (addr[0]),
        .dbus_be     (be[0]),
        .dbus_wr_en  (wr[0]),
        .dbus_wr_data(wdata[0]),
        .dbus_rd_en  (rd[0]),
        .dbus_rd_data(rdata[0]),
        .dbus_busy   (busy[0]),
        .dbus_ack    (ack[0])
    );

    dbus_ram_responder #(
        .p_addr_width (AW),
        .p_base_addr  (BASE),
        .p_wait_states(3)
    ) u_dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .dbus_addr   (addr[1]),
        .dbus_be     (be[1]),
        .dbus_wr_en  (wr[1]),
        .dbus_wr_data(wdata[1]),
        .dbus_rd_en  (rd[1]),
        .dbus_rd_data(rdata[1]),
        .dbus_busy   (busy[1]),
        .dbus_ack    (ack[1])
    );

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: ec counts clock edges; an accept at edge e makes the intervals after edges
    // e..e+W-1 busy, the interval after edge e+W the ack, and the next accept legal at e+W+1.
    longint      ec = 0;
    longint      acc_edge  [2];
    longint      free_edge [2];
    logic [31:0] exp_rd    [2];
    logic [31:0] mmem      [2][1024];

    always @(posedge clk or negedge rst_n) begin
        int unsigned idx;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                exp_rd[i]    = 32'd0;
                acc_edge[i]  = -1000;
                free_edge[i] = 0;
            end
        end else begin
            ec = ec + 1;
            for (int i = 0; i < 2; i++) begin
                if ((wr[i] || rd[i]) && (addr[i][31:AW+2] == BASE[31:AW+2]) && (ec >= free_edge[i])) begin
                    idx = int'(addr[i][AW+1:2]);
                    if (rd[i]) exp_rd[i] = mmem[i][idx];
                    if (wr[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[i][b]) mmem[i][idx][8*b +: 8] = wdata[i][8*b +: 8];
                        end
                    end
                    acc_edge[i]  = ec;
                    free_edge[i] = ec + longint'(ws_of(i)) + 1;
                end
            end
        end
    end

    function automatic logic m_busy(input int i);
        return (ec >= acc_edge[i]) && (ec < acc_edge[i] + longint'(ws_of(i)));
    endfunction

    function automatic logic m_ack(input int i);
        return ec == acc_edge[i] + longint'(ws_of(i));
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("busy%0d@%0d", i, ec), busy[i], m_busy(i));
            check($sformatf("ack%0d@%0d", i, ec), ack[i], m_ack(i));
            check($sformatf("rd_data%0d@%0d", i, ec), rdata[i], exp_rd[i]);
        end
    end

    task automatic idle(input int i);
        wr[i] = 1'b0;
        rd[i] = 1'b0;
    endtask

    // Drives a request at posedge+1 and returns the number of edges until ack is seen.
    task automatic xfer(input int i, input logic w, input logic r, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, output int lat);
        addr[i]  = a;
        be[i]    = b;
        wr[i]    = w;
        rd[i]    = r;
        wdata[i] = d;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ack[i] && lat < 20);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int unsigned k;
        logic [1:0]  op;
        logic [31:0] up;
        for (int i = 0; i < 2; i++) begin
            idle(i);
            addr[i]  = 32'd0;
            be[i]    = 4'd0;
            wdata[i] = 32'd0;
        end
        #1 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            check("rst_busy0", busy[0], 1'b0);
            check("rst_ack1", ack[1], 1'b0);
            check("rst_rd0", rdata[0], 32'd0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 16; w++) begin
                xfer(i, 1'b1, 1'b0, BASE + 32'(w * 4), 4'hF, $urandom, lat);
            end
            idle(i);
        end
        @(posedge clk);
        #1;

        // W=0 write then read, followed by byte-lane merges and a be=0000 no-op write
        xfer(0, 1'b1, 1'b0, 32'h0001_0004, 4'b1111, 32'hDEAD_BEEF, lat);
        check("w0_wr_lat", lat, 1);
        xfer(0, 1'b0, 1'b1, 32'h0001_0004, 4'b0000, 32'd0, lat);
        check("w0_rd_lat", lat, 1);
        check("w0_rd_data", rdata[0], 32'hDEAD_BEEF);
        xfer(0, 1'b1, 1'b0, 32'h0001_0004, 4'b0100, 32'h00AB_0000, lat);
        xfer(0, 1'b1, 1'b0, 32'h0001_0004, 4'b0011, 32'h0000_1234, lat);
        xfer(0, 1'b0, 1'b1, 32'h0001_0004, 4'b0000, 32'd0, lat);
        check("lanes_rd", rdata[0], 32'hDEAB_1234);
        xfer(0, 1'b1, 1'b0, 32'h0001_0004, 4'b0000, 32'hFFFF_FFFF, lat);
        check("be0_acked", ack[0], 1'b1);
        xfer(0, 1'b0, 1'b1, 32'h0001_0004, 4'b0000, 32'd0, lat);
        check("be0_unchanged", rdata[0], 32'hDEAB_1234);

        // Asynchronous reset asserted mid-cycle while an ack is showing
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rd", rdata[0], 32'd0);
        check("async_rst_ack", ack[0], 1'b0);
        idle(0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unselected window: invisible to the RAM and to the handshake
        xfer(0, 1'b0, 1'b1, 32'h0002_0000, 4'b0000, 32'd0, lat);
        check("unsel_no_ack", lat, 20);
        xfer(0, 1'b1, 1'b0, 32'h0002_0004, 4'b1111, 32'h0BAD_0BAD, lat);
        check("unsel_wr_no_ack", lat, 20);
        xfer(0, 1'b0, 1'b1, 32'h0001_0004, 4'b0000, 32'd0, lat);
        check("unsel_ram_kept", rdata[0], 32'hDEAB_1234);

        // Read-first on a combined read/write
        xfer(0, 1'b1, 1'b0, 32'h0001_0008, 4'b1111, 32'h1111_1111, lat);
        xfer(0, 1'b1, 1'b1, 32'h0001_0008, 4'b1111, 32'h2222_2222, lat);
        check("rdfirst_old", rdata[0], 32'h1111_1111);
        xfer(0, 1'b0, 1'b1, 32'h0001_0008, 4'b0000, 32'd0, lat);
        check("rdfirst_new", rdata[0], 32'h2222_2222);
        idle(0);

        // W=3: read held through the wait cycles, then an immediate follow-on request
        xfer(1, 1'b1, 1'b0, 32'h0001_0004, 4'b1111, 32'h5A5A_A5A5, lat);
        check("w3_wr_lat", lat, 4);
        xfer(1, 1'b0, 1'b1, 32'h0001_0004, 4'b0000, 32'd0, lat);
        check("w3_rd_lat", lat, 4);
        check("w3_rd_data", rdata[1], 32'h5A5A_A5A5);
        xfer(1, 1'b0, 1'b1, 32'h0001_0000, 4'b0000, 32'd0, lat);
        check("w3_b2b_lat", lat, 4);

        // Reset pulsed during the wait of a W=3 write
        addr[1]  = 32'h0001_000C;
        be[1]    = 4'b1111;
        wdata[1] = 32'hCAFE_F00D;
        wr[1]    = 1'b1;
        rd[1]    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("midwait_busy", busy[1], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midwait_rst_busy", busy[1], 1'b0);
        idle(1);
        #3 rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        xfer(1, 1'b0, 1'b1, 32'h0001_000C, 4'b0000, 32'd0, lat);
        check("midwait_rd_lat", lat, 4);
        check("midwait_committed", rdata[1], 32'hCAFE_F00D);
        idle(1);

        // Randomized traffic on both instances; requests are held while busy
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!busy[i]) begin
                    k = $urandom_range(0, 9);
                    if (k < 2) begin
                        idle(i);
                    end else begin
                        op       = 2'($urandom_range(1, 3));
                        wr[i]    = op[0];
                        rd[i]    = op[1];
                        be[i]    = 4'($urandom);
                        wdata[i] = $urandom;
                        addr[i]  = BASE + 32'($urandom_range(0, 15) * 4);
                        if (k == 9) begin
                            up = $urandom;
                            if (up[31:AW+2] == BASE[31:AW+2]) up[31] = ~up[31];
                            addr[i] = {up[31:2], 2'b00};
                        end
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        idle(0);
        idle(1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
